// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: requester, response, ALU and status signals of the shared-ALU arbiter
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
);
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req1_a;
    logic [WIDTH-1:0] req0_b, req1_b;
    logic [OP_W-1:0]  req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_c, rsp1_c;
    logic             rsp0_eq, rsp1_eq;
    logic             rsp0_illegal, rsp1_illegal;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] alu_c;
    logic             alu_eq;
    logic             busy;
    logic             grant_id;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
        input  rsp0_ready, rsp1_ready, alu_c, alu_eq,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_c, rsp1_c,
        output rsp0_eq, rsp1_eq, rsp0_illegal, rsp1_illegal, alu_a, alu_b, alu_op,
        output busy, grant_id
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
        output rsp0_ready, rsp1_ready, alu_c, alu_eq,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_c, rsp1_c,
        input  rsp0_eq, rsp1_eq, rsp0_illegal, rsp1_illegal, alu_a, alu_b, alu_op,
        input  busy, grant_id
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input logic clk,
    input logic reset_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_n;
    logic             ptr, gid, ill, eq_q, win, accept, done;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [OP_W-1:0]  op_q, op_sel;

    // next state, arbitration and all combinational outputs
    always_comb begin
        win            = (bus.req0_valid && bus.req1_valid) ? ptr : bus.req1_valid;
        op_sel         = win ? bus.req1_op : bus.req0_op;
        accept         = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        done           = (state == RESP) && (gid ? bus.rsp1_ready : bus.rsp0_ready);
        state_n        = accept ? EXEC : (state == EXEC) ? RESP : done ? IDLE : state;
        bus.req0_ready = (state == IDLE) && bus.req0_valid && !win;
        bus.req1_ready = (state == IDLE) && bus.req1_valid && win;
        bus.rsp0_valid = (state == RESP) && !gid;
        bus.rsp1_valid = (state == RESP) && gid;
        bus.rsp0_c       = c_q;
        bus.rsp1_c       = c_q;
        bus.rsp0_eq      = eq_q;
        bus.rsp1_eq      = eq_q;
        bus.rsp0_illegal = ill;
        bus.rsp1_illegal = ill;
        bus.alu_a    = (state == EXEC) ? a_q : '0;
        bus.alu_b    = (state == EXEC) ? b_q : '0;
        bus.alu_op   = (state == EXEC) ? op_q : '0;
        bus.busy     = state != IDLE;
        bus.grant_id = gid;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // operand latch on accept, result capture in EXEC, pointer hand-off on response handshake
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            gid  <= 1'b0;
            ill  <= 1'b0;
            c_q  <= '0;
            eq_q <= 1'b0;
            ptr  <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= win ? bus.req1_a : bus.req0_a;
                b_q  <= win ? bus.req1_b : bus.req0_b;
                op_q <= op_sel;
                gid  <= win;
                ill  <= op_sel > OP_W'(5);
            end
            if (state == EXEC) begin
                c_q  <= bus.alu_c;
                eq_q <= bus.alu_eq;
            end
            if (done)
                ptr <= ~gid;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the shared-ALU arbiter against a transaction-level model
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  v = 2'b00;
    logic [1:0]  rr = 2'b00;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [3:0]  op0 = '0, op1 = '0;
    logic        ptr_m = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          prev_acc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    alu_share_arbiter_if #(.WIDTH(32), .OP_W(4)) bus ();

    alu_share_arbiter #(.WIDTH(32), .OP_W(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.req0_valid = v[0];
    assign bus.req1_valid = v[1];
    assign bus.req0_a = a0;
    assign bus.req0_b = b0;
    assign bus.req0_op = op0;
    assign bus.req1_a = a1;
    assign bus.req1_b = b1;
    assign bus.req1_op = op1;
    assign bus.rsp0_ready = rr[0];
    assign bus.rsp1_ready = rr[1];

    wire [1:0] rdy = {bus.req1_ready, bus.req0_ready};
    wire [1:0] rv  = {bus.rsp1_valid, bus.rsp0_valid};

    // reference ALU behaviour taken from the opcode table
    function automatic logic [31:0] mc(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        case (o)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return {31'b0, $signed(x) < $signed(y)};
            4'd5:    return {31'b0, x < y};
            default: return 32'd0;
        endcase
    endfunction

    // the shared ALU itself, purely combinational
    always_comb begin
        bus.alu_c  = mc(bus.alu_a, bus.alu_b, bus.alu_op);
        bus.alu_eq = bus.alu_a == bus.alu_b;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one complete transaction: present, accept, EXEC, RESP with optional stall, handshake
    task automatic txn(input logic [1:0] vin,
                       input logic [31:0] xa0, input logic [31:0] xb0, input logic [3:0] xo0,
                       input logic [31:0] xa1, input logic [31:0] xb1, input logic [3:0] xo1,
                       input int stall, input bit pulse,
                       input bit dir, input logic [31:0] dc, input logic deq);
        logic        id;
        logic [31:0] ea, eb, ec, oc;
        logic [3:0]  eo;
        logic        eeq, oeq, oill;
        id = (vin == 2'b11) ? ptr_m : vin[1];
        a0 = xa0; b0 = xb0; op0 = xo0;
        a1 = xa1; b1 = xb1; op1 = xo1;
        v = vin;
        rr = id ? {stall == 0, 1'b1} : {1'b1, stall == 0};
        ea = id ? xa1 : xa0;
        eb = id ? xb1 : xb0;
        eo = id ? xo1 : xo0;
        ec = dir ? dc : mc(ea, eb, eo);
        eeq = dir ? deq : (ea == eb);
        #1;
        chk("req_ready_at_accept", 64'(rdy), id ? 64'd2 : 64'd1);
        prev_acc = acc_cyc;
        acc_cyc = cyc;
        @(negedge clk);
        v = pulse ? 2'b10 : 2'b00;
        #1;
        chk("exec_busy", 64'(bus.busy), 64'd1);
        chk("exec_grant", 64'(bus.grant_id), 64'(id));
        chk("exec_alu_op", 64'(bus.alu_op), 64'(eo));
        chk("exec_alu_a", 64'(bus.alu_a), 64'(ea));
        chk("exec_alu_b", 64'(bus.alu_b), 64'(eb));
        chk("exec_ready_gated", 64'(rdy), 64'd0);
        @(negedge clk);
        v = 2'b00;
        oc = id ? bus.rsp1_c : bus.rsp0_c;
        oeq = id ? bus.rsp1_eq : bus.rsp0_eq;
        oill = id ? bus.rsp1_illegal : bus.rsp0_illegal;
        chk("rsp_valid", 64'(rv), id ? 64'd2 : 64'd1);
        chk("rsp_c", 64'(oc), 64'(ec));
        chk("rsp_eq", 64'(oeq), 64'(eeq));
        chk("rsp_illegal", 64'(oill), 64'(eo > 4'd5));
        chk("resp_alu_op_zero", 64'(bus.alu_op), 64'd0);
        for (int k = 0; k < stall; k++) begin
            v = 2'b11;
            #1;
            chk("stall_ready_gated", 64'(rdy), 64'd0);
            @(negedge clk);
            chk("stall_rsp_valid", 64'(rv), id ? 64'd2 : 64'd1);
            chk("stall_rsp_c", 64'(id ? bus.rsp1_c : bus.rsp0_c), 64'(ec));
            chk("stall_rsp_eq", 64'(id ? bus.rsp1_eq : bus.rsp0_eq), 64'(eeq));
        end
        v = 2'b00;
        rr = 2'b11;
        @(negedge clk);
        chk("post_rsp_valid", 64'(rv), 64'd0);
        chk("post_busy", 64'(bus.busy), 64'd0);
        ptr_m = !id;
    endtask

    initial begin
        logic [1:0]  rv_in;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [3:0]  ro0, ro1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_grant", 64'(bus.grant_id), 64'd0);
        chk("reset_rsp_valid", 64'(rv), 64'd0);
        chk("reset_rsp_c", 64'(bus.rsp0_c), 64'd0);
        chk("reset_rsp_eq", 64'(bus.rsp1_eq), 64'd0);
        chk("reset_rsp_illegal", 64'(bus.rsp0_illegal), 64'd0);
        chk("reset_alu_op", 64'(bus.alu_op), 64'd0);
        chk("reset_req_ready", 64'(rdy), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        ptr_m = 1'b0;

        // contention: grants alternate 0,1,0,1 with accepts three cycles apart
        for (int i = 0; i < 4; i++) begin
            txn(2'b11, 32'd1, 32'd1, 4'd0, 32'hFFFFFFFF, 32'd1, 4'd4, 0, 1'b0,
                1'b1, (i % 2 == 0) ? 32'd2 : 32'd1, (i % 2 == 0));
            chk("contention_grant", 64'(ptr_m), (i % 2 == 0) ? 64'd1 : 64'd0);
            if (i > 0) chk("accept_spacing", 64'(acc_cyc - prev_acc), 64'd3);
        end

        // single subtract on requester 0
        txn(2'b01, 32'd7, 32'd5, 4'd1, 32'd0, 32'd0, 4'd0, 0, 1'b0, 1'b1, 32'd2, 1'b0);
        // back-pressure on requester 1
        txn(2'b10, 32'd0, 32'd0, 4'd0, 32'hFFFFFFFF, 32'd1, 4'd5, 5, 1'b0, 1'b1, 32'd0, 1'b0);
        // illegal opcode
        txn(2'b01, 32'd3, 32'd3, 4'd9, 32'd0, 32'd0, 4'd0, 0, 1'b0, 1'b1, 32'd0, 1'b1);
        // requester 1 pulses valid while busy and is never served
        txn(2'b01, 32'd10, 32'd4, 4'd3, 32'd1, 32'd2, 4'd0, 0, 1'b1, 1'b1, 32'd14, 1'b0);
        #1;
        chk("withdrawn_not_accepted", 64'(rdy), 64'd0);

        // reset while the response is pending
        a0 = 32'd4; b0 = 32'd4; op0 = 4'd0;
        v = 2'b01;
        rr = 2'b00;
        @(negedge clk);
        v = 2'b00;
        @(negedge clk);
        chk("midreset_rsp_pending", 64'(rv), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_rsp_valid", 64'(rv), 64'd0);
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_grant", 64'(bus.grant_id), 64'd0);
        chk("midreset_rsp_c", 64'(bus.rsp0_c), 64'd0);
        chk("midreset_rsp_eq", 64'(bus.rsp0_eq), 64'd0);
        chk("midreset_alu_a", 64'(bus.alu_a), 64'd0);
        reset_n = 1'b1;
        rr = 2'b11;
        ptr_m = 1'b0;
        @(negedge clk);
        txn(2'b11, 32'd6, 32'd2, 4'd2, 32'd9, 32'd9, 4'd1, 0, 1'b0, 1'b1, 32'd2, 1'b0);
        chk("after_reset_first_grant", 64'(ptr_m), 64'd1);

        // randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            rv_in = 2'($urandom_range(1, 3));
            ra0 = $urandom;
            rb0 = ($urandom % 4 == 0) ? ra0 : $urandom;
            ra1 = $urandom;
            rb1 = ($urandom % 4 == 0) ? ra1 : $urandom;
            ro0 = 4'($urandom % 8);
            ro1 = 4'($urandom % 8);
            txn(rv_in, ra0, rb0, ro0, ra1, rb1, ro1, int'($urandom_range(0, 2)), 1'($urandom % 2),
                1'b0, 32'd0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
